// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer sharing one signed Booth multiplier among NREQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT cycles (rsp_err on abort).
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 15,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_z,
    output logic [IW-1:0]       rsp_id,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [W-1:0]        mul_x,
    output logic [W-1:0]        mul_y,
    input  logic                mul_valid,
    input  logic [2*W-1:0]      mul_z
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]  rsp_z_q, rsp_z_d;
    logic            busy_q, busy_d;
    logic            mul_start_q, mul_start_d;
    logic [W-1:0]    mul_x_q, mul_x_d;
    logic [W-1:0]    mul_y_q, mul_y_d;
    logic            sel_hit;
    logic [IW-1:0]   sel_id;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          rsp_err_q, rsp_err_d;

    assign cnt_inc = cnt_q + CW'(1);
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // First set request at or above ptr, wrapping past NREQ-1.
    always_comb begin
        int idx;
        idx     = 0;
        sel_hit = 1'b0;
        sel_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_hit && req[idx]) begin
                sel_hit = 1'b1;
                sel_id  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_z_d     = rsp_z_q;
        busy_d      = busy_q;
        mul_start_d = 1'b0;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sel_hit) begin
                    state_d     = S_ISSUE;
                    id_d        = sel_id;
                    mul_x_d     = req_x[int'(sel_id)*W +: W];
                    mul_y_d     = req_y[int'(sel_id)*W +: W];
                    gnt_d       = NREQ'(1) << sel_id;
                    mul_start_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (mul_valid) begin
                    state_d     = S_RESP;
                    rsp_z_d     = mul_z;
                    rsp_valid_d = NREQ'(1) << id_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d     = S_RESP;
                    rsp_z_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NREQ'(1) << id_q;
                end else begin
                    cnt_d = cnt_inc;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier.
// Honours BOOTH_ARB_TIMEOUT_EN when deciding what a stalled multiply returns.
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_z;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic              mul_valid;
    logic [2*W-1:0]    mul_z;

    booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]  id;
        logic [2*W-1:0] z;
        logic           err;
    } rsp_t;

    rsp_t          sq[$];
    logic [IW-1:0] gq[$];
    int total = 0;
    int bad   = 0;
    int nresp = 0;
    int mptr  = 0;
    int spur_req = 0;
    bit stall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return p;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_z"}, 32'(rsp_z), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mul_start"}, 32'(mul_start), 0);
        chk({tag, "_mul_x"}, 32'(mul_x), 0);
        chk({tag, "_mul_y"}, 32'(mul_y), 0);
    endtask

    // Monitor: every grant and response is matched against the queues.
    initial begin
        logic [IW-1:0] g;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (gnt != '0) begin
                    if (gq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_gnt got=%b", gnt);
                    end else begin
                        g = gq.pop_front();
                        chk("gnt", 32'(gnt), 32'(NREQ'(1) << g));
                    end
                end
                if (rsp_valid != '0) begin
                    if (sq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp got=%b", rsp_valid);
                    end else begin
                        e = sq.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.id));
                        chk("rsp_z", 32'(rsp_z), 32'(e.z));
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    nresp++;
                end
            end
        end
    end

    // Behavioural multiplier with random latency and stray valid pulses.
    initial begin
        logic [W-1:0] cx;
        logic [W-1:0] cy;
        int lat;
        int spur_done;
        spur_done = 0;
        mul_valid = 1'b0;
        mul_z     = '0;
        forever begin
            @(negedge clk);
            if (mul_start && !stall) begin
                cx  = mul_x;
                cy  = mul_y;
                lat = $urandom_range(1, 4);
                if ($urandom_range(0, 2) == 0) begin
                    mul_valid = 1'b1;
                    mul_z     = 8'($urandom);
                    @(negedge clk);
                    mul_valid = 1'b0;
                end
                repeat (lat) @(negedge clk);
                chk("mul_x_hold", 32'(mul_x), 32'(cx));
                chk("mul_y_hold", 32'(mul_y), 32'(cy));
                mul_valid = 1'b1;
                mul_z     = prod(cx, cy);
                @(negedge clk);
                mul_valid = 1'b0;
            end else if (spur_req != spur_done) begin
                mul_valid = 1'b1;
                mul_z     = 8'($urandom);
                @(negedge clk);
                mul_valid = 1'b0;
                spur_done++;
            end
        end
    end

    task automatic run_batch(input logic [NREQ-1:0] m,
                             input logic [NREQ*W-1:0] xs,
                             input logic [NREQ*W-1:0] ys);
        int tgt;
        int last;
        tgt  = nresp;
        last = mptr;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (m[i]) begin
                gq.push_back(IW'(i));
                sq.push_back('{id: IW'(i),
                               z: prod(xs[i*W +: W], ys[i*W +: W]),
                               err: 1'b0});
                tgt++;
                last = i;
            end
        end
        mptr  = (last + 1) % NREQ;
        req_x = xs;
        req_y = ys;
        req   = m;
        for (int c = 0; c < 400 && nresp < tgt; c++) begin
            @(negedge clk);
            req = req & ~gnt;
        end
        chk("batch_done", 32'(nresp >= tgt), 1);
        req = '0;
        @(negedge clk);
    endtask

    task automatic wait_gnt(input int i);
        for (int c = 0; c < 20 && !gnt[i]; c++) @(negedge clk);
        chk("gnt_seen", 32'(gnt[i]), 1);
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int n0;
        req   = '0;
        req_x = '0;
        req_y = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b1;

        run_batch(4'b1111, 16'($urandom), 16'($urandom));
        run_batch(4'b0001, 16'h0003, 16'h000E);
        run_batch(4'b0100, 16'h0800, 16'h0800);
        run_batch(4'b0100, 16'h0800, 16'h0700);

        spur_req++;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", 32'(busy), 0);

        for (int t = 0; t < 30; t++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_batch(m, 16'($urandom), 16'($urandom));
        end

        stall = 1'b1;
        n0 = nresp;
        gq.push_back(IW'(3));
`ifdef BOOTH_ARB_TIMEOUT_EN
        sq.push_back('{id: IW'(3), z: '0, err: 1'b1});
`endif
        req_x = 16'($urandom);
        req_y = 16'($urandom);
        req   = 4'b1000;
        wait_gnt(3);
        req = '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
        for (int c = 0; c < 40 && nresp == n0; c++) @(negedge clk);
        chk("timeout_rsp", 32'(nresp - n0), 1);
        mptr = 0;
        @(negedge clk);
`else
        repeat (30) @(negedge clk);
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_no_rsp", 32'(nresp - n0), 0);
        rst = 1'b0;
        #1;
        chk_reset("rst_stuck");
        @(negedge clk);
        rst  = 1'b1;
        mptr = 0;
`endif
        stall = 1'b0;

        run_batch(4'b0100, 16'($urandom), 16'($urandom));

        stall = 1'b1;
        gq.push_back(IW'(1));
        req_x = 16'h00A0;
        req_y = 16'h0050;
        req   = 4'b0010;
        wait_gnt(1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("rst_wait");
        repeat (2) @(negedge clk);
        stall = 1'b0;
        rst   = 1'b1;
        mptr  = 0;
        run_batch(4'b0010, 16'h00A0, 16'h0050);

        run_batch(4'b1010, 16'($urandom), 16'($urandom));
        repeat (5) @(negedge clk);
        chk("gq_empty", 32'(gq.size()), 0);
        chk("sq_empty", 32'(sq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one signed W x W Booth multiplier between NREQ requesters. It accepts one operand pair at a time, issues a one-cycle start to the multiplier and holds the operands stable until the multiplier's valid arrives. It then routes the 2W-bit product back to the requester that was granted. The block sits between the requesting datapaths and the single multiplier instance; the multiplier connects through the mul_* ports.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, signed operand width; product width is 2W
TIMEOUT, 15, max WAIT cycles before abort (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req  in  NREQ  request per requester; held high with operands until gnt
req_x  in  NREQ*W  packed multiplicands; slice i = bits [i*W +: W]
req_y  in  NREQ*W  packed multipliers; same packing as req_x
gnt  out  NREQ  one-hot, one-cycle pulse; request accepted
rsp_valid  out  NREQ  one-hot, one-cycle pulse; product ready for requester i
rsp_z  out  2W  signed product, valid while any rsp_valid bit is high
rsp_id  out  clog2(NREQ)  index of the current/last granted requester
rsp_err  out  1  timeout flag, qualifies rsp_valid
busy  out  1  high in every state except IDLE
mul_start  out  1  one-cycle start pulse to the multiplier
mul_x  out  W  multiplicand to the multiplier; held stable through ISSUE and WAIT
mul_y  out  W  multiplier operand; held stable through ISSUE and WAIT
mul_valid  in  1  multiplier done pulse
mul_z  in  2W  multiplier product, sampled when mul_valid is high

Behaviour:
- All outputs are registered. On rst low: state=IDLE, ptr=0, gnt=0, rsp_valid=0, rsp_z=0, rsp_id=0, rsp_err=0, busy=0, mul_start=0, mul_x=0, mul_y=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, select the first set bit searching upward from ptr with wrap-around.
  - Latch id, req_x[id] and req_y[id] into mul_x and mul_y.
  - Next state is ISSUE.
  - If req is all zero, stay in IDLE.
- ISSUE (exactly 1 cycle): gnt[id]=1, mul_start=1, busy=1. Next state is WAIT.
- WAIT:
  - gnt=0, mul_start=0; mul_x and mul_y stay unchanged.
  - When mul_valid=1: capture mul_z into rsp_z, next state is RESP.
- RESP (exactly 1 cycle):
  - rsp_valid[id]=1, rsp_err as computed.
  - ptr = (id+1) mod NREQ.
  - Next state is IDLE.
- rsp_z and rsp_id hold their values after RESP until the next capture or reset.
- req and operands are sampled only in IDLE.
  - Requests arriving while busy wait in line and receive no gnt until selected.
  - A requester may keep req high during its gnt cycle; it must drop req before the block returns to IDLE, otherwise the request is serviced again.
- mul_valid outside WAIT is ignored; no state change and no response.
- Latency: req seen at edge n gives gnt and mul_start in cycle n+1. With multiplier latency L (edges from start sample to valid), rsp_valid is high in cycle n+L+2. The minimum IDLE-to-IDLE period is L+3 cycles.
- Fairness: each active requester is granted at least once every NREQ transactions.
- Simultaneous requests: the lowest index at or above ptr wins; the winner then gets the lowest priority for the next arbitration.
- Reset mid-operation: any in-flight transaction is dropped with no rsp_valid, ptr returns to 0, and mul_start is low from reset onward.
- rsp_z is signed and taken unmodified from mul_z; the block does no arithmetic on the product.

Optional Feature:
BOOTH_ARB_TIMEOUT_EN:
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no mul_valid, the FSM goes to RESP with rsp_z=0 and rsp_err=1.
  - A mul_valid in the same cycle as the timeout wins, giving normal completion with rsp_err=0.
- Not defined: WAIT has no bound; the rsp_err port stays present and is tied to 0.

Test Plan:
- Single request: req=4'b0001, x=3, y=-2 -> gnt[0] pulses in the cycle after req; mul_start is a single pulse; rsp_valid[0] pulses with rsp_z=8'hFA, rsp_id=0.
- Corner operands on requester 2: x=-8, y=-8 -> rsp_z=8'h40. Then x=-8, y=7 -> rsp_z=8'hC8. Check mul_x/mul_y stable from ISSUE through WAIT.
- All four requesters held high from reset -> grant order 0,1,2,3,0, each grant after the previous RESP; no lost or duplicated rsp_valid.
- Spurious mul_valid in IDLE or ISSUE -> no rsp_valid and no state change; the later real mul_valid in WAIT completes normally.
- rst low during WAIT -> all outputs return to reset values at once; after release, the pending req is re-granted from ptr=0 with no stale rsp_valid.
- With BOOTH_ARB_TIMEOUT_EN, TIMEOUT=15, mul_valid held 0 -> rsp_valid[id] with rsp_err=1 and rsp_z=0 after 15 WAIT cycles. Without the macro, the block stays in WAIT and busy stays 1.
